rs_latch_driver: RTL and testbench

Synchronous controller that drives the active-low set/reset inputs of a basic RS latch (notS/notR), sitting between clocked logic and the asynchronous latch. It accepts set or clear requests over a valid/ready handshake and emits a fixed-width active-low pulse on exactly one latch input, never both at once. It then confirms the latch outputs Q/notQ through a two-flop synchronizer and reports either completion or a timeout.

---
 rtl/rs_latch_driver_if.sv | 26 ++
 rtl/rs_latch_driver.sv | 135 +++++++++++++
 tb/tb_rs_latch_driver.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_latch_driver_if.sv
// Bundles the request handshake and latch drive/feedback wires of rs_latch_driver.
// The controller uses the slave modport; the requester/latch side uses master.
interface rs_latch_driver_if;
  logic req_valid;
  logic req_set;
  logic req_ready;
  logic notS;
  logic notR;
  logic Q;
  logic notQ;
  logic done;
  logic err;
  logic q_state;
  logic q_valid;
  logic busy;

  modport master (
    output req_valid, req_set, Q, notQ,
    input  req_ready, notS, notR, done, err, q_state, q_valid, busy
  );

  modport slave (
    input  req_valid, req_set, Q, notQ,
    output req_ready, notS, notR, done, err, q_state, q_valid, busy
  );
endinterface

// File: rtl/rs_latch_driver.sv
// Clocked driver for an active-low RS latch: pulses exactly one of notS/notR,
// then confirms Q/notQ through a two-flop synchronizer, reporting done or err.
module rs_latch_driver #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic            clk,
  input  logic            notReset,
  rs_latch_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    CONFIRM = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  generate
    if (PULSE_CYCLES < 2) begin : g_bad_pulse
      $error("PULSE_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be at least 1");
    end
    if ((2 ** CNT_W) <= PULSE_CYCLES || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt
      $error("CNT_W too narrow for PULSE_CYCLES/TIMEOUT_CYCLES");
    end
  endgenerate

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             set_q;
  logic             nots_q;
  logic             notr_q;
  logic             done_q;
  logic             err_q;
  logic             qstate_q;
  logic             qvalid_q;
  logic [1:0]       q_sync_q;
  logic [1:0]       nq_sync_q;

  logic qs;
  logic nqs;
  logic match;

  // Latch outputs are asynchronous; both rails are synchronized every cycle.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      q_sync_q  <= 2'b00;
      nq_sync_q <= 2'b00;
    end else begin
      q_sync_q  <= {q_sync_q[0], bus.Q};
      nq_sync_q <= {nq_sync_q[0], bus.notQ};
    end
  end

  assign qs  = q_sync_q[1];
  assign nqs = nq_sync_q[1];
  // Requiring complementary rails rejects the forbidden/metastable qs==nqs case.
  assign match = (qs == set_q) && (nqs == ~set_q);

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      set_q    <= 1'b0;
      nots_q   <= 1'b1;
      notr_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      qstate_q <= 1'b0;
      qvalid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            set_q   <= bus.req_set;
            cnt_q   <= '0;
            nots_q  <= ~bus.req_set;
            notr_q  <= bus.req_set;
            state_q <= PULSE;
          end
        end
        PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            nots_q  <= 1'b1;
            notr_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= CONFIRM;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        CONFIRM: begin
          if (match) begin
            done_q   <= 1'b1;
            qstate_q <= set_q;
            qvalid_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else if (cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          nots_q  <= 1'b1;
          notr_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.notS      = nots_q;
  assign bus.notR      = notr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.q_state   = qstate_q;
  assign bus.q_valid   = qvalid_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Bench for rs_latch_driver with a behavioural RS latch and a response scoreboard.
module tb_rs_latch_driver;
  localparam int P = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic notReset = 1'b0;
  always #5 clk = ~clk;

  rs_latch_driver_if bus();

  rs_latch_driver #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk),
    .notReset(notReset),
    .bus(bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic lq = 1'b0;
  logic stuck = 1'b0;

  // Behavioural latch; stuck forces the Q=0/notQ=1 rails regardless of drives.
  always @(bus.notS, bus.notR) begin
    if (!bus.notS) lq = 1'b1;
    else if (!bus.notR) lq = 1'b0;
  end
  assign bus.Q    = stuck ? 1'b0 : lq;
  assign bus.notQ = stuck ? 1'b1 : ~lq;

  typedef struct {
    logic is_err;
    logic set;
    int   acc;
  } exp_t;
  exp_t sb[$];
  logic mq = 1'b0;
  logic mqv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: drive invariant every cycle, scoreboard for done/err.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    int   exp_lat;
    logic exp_q;
    logic exp_qv;
    checks++;
    if ((bus.notS | bus.notR) !== 1'b1) begin
      errors++;
      $display("FAIL invariant notS=%b notR=%b at cycle %0d", bus.notS, bus.notR, cyc);
    end
    if (!notReset) begin
      sb.delete();
      mq = 1'b0;
      mqv = 1'b0;
    end else begin
      if (bus.done || bus.err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response done=%b err=%b at cycle %0d", bus.done, bus.err, cyc);
        end else begin
          e = sb.pop_front();
          lat = cyc - e.acc;
          exp_lat = e.is_err ? (P + T) : (P + 1);
          exp_q  = e.is_err ? mq : e.set;
          exp_qv = e.is_err ? mqv : 1'b1;
          if (bus.err !== e.is_err || bus.done !== ~e.is_err) begin
            errors++;
            $display("FAIL sb_kind got done=%b err=%b want err=%b", bus.done, bus.err, e.is_err);
          end
          checks++;
          if (lat != exp_lat) begin
            errors++;
            $display("FAIL sb_latency got %0d want %0d", lat, exp_lat);
          end
          checks++;
          if (bus.q_state !== exp_q || bus.q_valid !== exp_qv) begin
            errors++;
            $display("FAIL sb_qstate got q=%b v=%b want q=%b v=%b", bus.q_state, bus.q_valid, exp_q, exp_qv);
          end
          mq = exp_q;
          mqv = exp_qv;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        e.is_err = stuck;
        e.set = bus.req_set;
        e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  // Issues one request and measures drive widths and response latency.
  task automatic run_req(input logic set, output int s_low, output int r_low,
                         output int lat, output logic got_done, output logic got_err);
    s_low = 0; r_low = 0; lat = -1; got_done = 1'b0; got_err = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_set = set;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!bus.notS) s_low++;
      if (!bus.notR) r_low++;
      if (bus.done || bus.err) begin
        lat = n - 1;
        got_done = bus.done;
        got_err = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    notReset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_set   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checks++; if (bus.notS !== 1'b1)      begin errors++; $display("FAIL reset_notS got %b want 1", bus.notS); end
    checks++; if (bus.notR !== 1'b1)      begin errors++; $display("FAIL reset_notR got %b want 1", bus.notR); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (bus.q_valid !== 1'b0)   begin errors++; $display("FAIL reset_qvalid got %b want 0", bus.q_valid); end
    checks++; if (bus.q_state !== 1'b0)   begin errors++; $display("FAIL reset_qstate got %b want 0", bus.q_state); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    notReset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_set_clear(input logic set);
    int s_low, r_low, lat;
    logic gd, ge;
    run_req(set, s_low, r_low, lat, gd, ge);
    checks++; if (s_low != (set ? P : 0)) begin errors++; $display("FAIL drive_notS_width set=%b got %0d want %0d", set, s_low, set ? P : 0); end
    checks++; if (r_low != (set ? 0 : P)) begin errors++; $display("FAIL drive_notR_width set=%b got %0d want %0d", set, r_low, set ? 0 : P); end
    checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL confirm_kind set=%b done=%b err=%b want done", set, gd, ge); end
    checks++; if (lat != P + 1) begin errors++; $display("FAIL done_latency set=%b got %0d want %0d", set, lat, P + 1); end
    checks++; if (bus.q_state !== set || bus.q_valid !== 1'b1) begin
      errors++; $display("FAIL confirm_qstate got q=%b v=%b want q=%b v=1", bus.q_state, bus.q_valid, set);
    end
  endtask

  task automatic test_stuck();
    int s_low, r_low, lat;
    logic gd, ge;
    stuck = 1'b1;
    run_req(1'b1, s_low, r_low, lat, gd, ge);
    checks++; if (s_low != P) begin errors++; $display("FAIL stuck_notS_width got %0d want %0d", s_low, P); end
    checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL stuck_kind done=%b err=%b want err", gd, ge); end
    checks++; if (lat != P + T) begin errors++; $display("FAIL err_latency got %0d want %0d", lat, P + T); end
    checks++; if (bus.q_state !== 1'b0 || bus.q_valid !== 1'b1) begin
      errors++; $display("FAIL stuck_qstate got q=%b v=%b want q=0 v=1", bus.q_state, bus.q_valid);
    end
    @(posedge clk); #1;
    stuck = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_set = 1'($urandom_range(0, 1));
    while (acc.size() < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.req_ready) begin
        acc.push_back(cyc + 1);
        @(posedge clk); #1;
        bus.req_set = 1'($urandom_range(0, 1));
        if (acc.size() == 8) bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    checks++; if (acc.size() != 8) begin errors++; $display("FAIL b2b_accepts got %0d want 8", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != P + 2) begin
        errors++; $display("FAIL b2b_spacing idx %0d got %0d want %0d", i, acc[i] - acc[i-1], P + 2);
      end
    end
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain pending %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid_pulse();
    int resp = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_set = ~bus.q_state;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    checks++; if ((bus.notS & bus.notR) !== 1'b0) begin errors++; $display("FAIL mid_pulse_active notS=%b notR=%b want one low", bus.notS, bus.notR); end
    notReset = 1'b0;
    #1;
    checks++; if (bus.notS !== 1'b1 || bus.notR !== 1'b1) begin errors++; $display("FAIL async_release notS=%b notR=%b want 1/1", bus.notS, bus.notR); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    notReset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.err) resp++;
    end
    checks++; if (resp != 0) begin errors++; $display("FAIL aborted_response got %0d want 0", resp); end
    checks++; if (bus.q_valid !== 1'b0 || bus.q_state !== 1'b0) begin
      errors++; $display("FAIL post_reset_q got q=%b v=%b want 0/0", bus.q_state, bus.q_valid);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_set = 1'b0;
    test_reset();
    test_set_clear(1'b1);
    test_set_clear(1'b0);
    test_stuck();
    test_back_to_back();
    test_reset_mid_pulse();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
